instruction_fetch_unit: RTL
===========================

# instruction_fetch_unit

Fetch stage of the 32-bit pipelined CPU. It sits directly upstream of the fetch/decode pipeline register:
- owns the program counter;
- issues word reads to instruction memory over a req/ack handshake;
- buffers up to two fetched instructions in a skid FIFO;
- presents them to the fetch/decode register as `pc_value_next` / `next_instruction`, qualified by `fd_load_enable`.

It also absorbs decode stalls and branch/jump redirects, including redirects that arrive while a memory read is outstanding.

## Interface
- `RESET_PC`, 32'h0000_0000, first fetch address after reset
- `clk`  in  1  clock; all state updates on rising edge
- `rst`  in  1  reset, asynchronous, active-low
- `stall`  in  1  hazard unit: fetch/decode register must hold this cycle
- `redirect_valid`  in  1  one-cycle pulse: resteer fetch to `redirect_pc`
- `redirect_pc`  in  32  redirect target; bits [1:0] ignored (treated as 0)
- `imem_req`  out  1  read request; held high until ack
- `imem_addr`  out  32  word-aligned read address; stable while `imem_req` high
- `imem_ack`  in  1  one-cycle pulse; `imem_rdata` valid in the same cycle
- `imem_rdata`  in  32  instruction word
- `fd_load_enable`  out  1  FIFO head valid and accepted by the fetch/decode register this cycle
- `pc_value_next`  out  32  FIFO head: fetch address + 4
- `next_instruction`  out  32  FIFO head: instruction word

## Operation
- **Registers:**
  - `fetch_pc` (32): next address to request.
  - `req_addr` (32): drives `imem_addr`.
  - 2-entry FIFO of {pc+4, instr} with 2-bit `count`.
  - 2-bit state.
- **States:**
  - IDLE: no request outstanding.
  - REQ: request outstanding, data wanted.
  - DISCARD: request outstanding, data to be dropped.
- `imem_req` = (state == REQ or state == DISCARD).
- **pop:** `fd_load_enable` = (count != 0) & !stall & !redirect_valid. When pop is high, the head entry is removed at the edge.
- **push:** in REQ with `imem_ack` and no `redirect_valid`, the entry {`req_addr`+4, `imem_rdata`} is written at the FIFO tail and `fetch_pc` <= `req_addr`+4.
- **Launch rule:** a new request launches only if count - pop + push <= 1. This guarantees a push never finds the FIFO full, so overflow is impossible by construction. On launch, `req_addr` <= the address being fetched.
- **Transitions:**
  - IDLE, no redirect: go to REQ with `req_addr` = `fetch_pc` if launch rule holds; else stay IDLE.
  - REQ, ack, no redirect: push. Stay in REQ with `req_addr` = `req_addr`+4 if launch rule holds; else go to IDLE.
  - REQ, no ack, no redirect: hold; `req_addr` stable.
  - REQ, no ack, redirect: go to DISCARD; `fetch_pc` <= `redirect_pc`; `req_addr` unchanged.
  - REQ, ack, redirect: data dropped; FIFO flushed. Launch at `redirect_pc` into REQ (always legal after flush); `fetch_pc` <= `redirect_pc`.
  - DISCARD, ack: data dropped. If no redirect, launch at `fetch_pc` into REQ. If redirect arrives in the same cycle, launch at `redirect_pc` into REQ and set `fetch_pc` <= `redirect_pc`.
  - DISCARD, no ack, redirect: `fetch_pc` <= `redirect_pc`; stay in DISCARD.
  - IDLE, redirect: flush; launch at `redirect_pc` into REQ.
- **redirect_valid (any state):**
  - FIFO flushed (count <= 0); no pop that cycle.
  - Takes priority over `stall`, push, and pop.
- **Arithmetic:** +4 is modulo 2^32; 32'hFFFF_FFFC wraps to 32'h0000_0000 with no fault.
- **stall:** affects only pop. Fetching continues until the FIFO plus the outstanding request reaches 2 entries.

## Timing
- **Reset (`rst` low, async):**
  - state IDLE, count 0, `fetch_pc` = `RESET_PC`, `req_addr` = `RESET_PC`.
  - `imem_req` = 0, `fd_load_enable` = 0; `pc_value_next` and `next_instruction` = 0.
- Reset asserted mid-request abandons it immediately. Memory must tolerate `imem_req` dropping without an ack on reset.
- **First request:** `imem_req` goes high on the first edge after `rst` deasserts, with `imem_addr` = `RESET_PC`.
- `imem_ack` is legal in any cycle `imem_req` is high, including the first.
- **Latency:** ack in cycle N gives the entry at the FIFO head and `fd_load_enable` high in N+1, provided there is no stall and no redirect.
- **Throughput:** with a single-cycle ack memory and no stall, one instruction per cycle.
- **Redirect to new instruction:**
  - From IDLE, or REQ with same-cycle ack, redirect in cycle N gives `imem_req` at `redirect_pc` in N+1.
  - Otherwise the new request issues the cycle after the pending ack.

## Test plan
1. **Reset and straight-line fetch.** Stimulus: `RESET_PC` = 32'h100; ack every cycle; `imem_rdata` = address. Response: `imem_addr` sequence 100, 104, 108; FD outputs {104, 100}, {108, 104}, … with `fd_load_enable` high every cycle from the second cycle after the first request.
2. **Stall fill.** Stimulus: `stall` = 1 for 5 cycles with 1-cycle ack. Response:
   - count reaches 2 and `imem_req` drops; `fd_load_enable` stays 0.
   - On release, two back-to-back loads, then fetch resumes at the next sequential address with no duplicate or skipped instruction.
3. **Redirect with outstanding request.** Stimulus: ack latency 3; `redirect_valid` pulse to 32'h200 one cycle after the request to 32'h104. Response:
   - `imem_addr` holds 104 until its ack; that data is dropped.
   - Next request is 200; the first FD output is {204, instr@200}.
4. **Redirect coincident with ack and stall.** Stimulus: `redirect_valid`, `imem_ack`, and `stall` all high together with count = 1. Response:
   - FIFO empties; no push and no `fd_load_enable` that cycle.
   - `imem_req` at `redirect_pc` the next cycle.
5. **Back-to-back redirects in DISCARD.** Stimulus: redirects to 32'h300 then 32'h400 before the pending ack. Response: only address 400 is fetched after the ack; 300 never appears on `imem_addr`.
6. **Wrap and misalignment.** Stimulus: `redirect_pc` = 32'hFFFF_FFFE. Response: `imem_addr` = FFFF_FFFC, then 0000_0000; `pc_value_next` = 0000_0000 for the first entry.

Source files
------------

// File: rtl/instruction_fetch_unit.sv
// Fetch stage: owns the PC, reads instruction memory over req/ack and feeds the
// fetch/decode register through a 2-entry skid FIFO, with stall and redirect handling.
module instruction_fetch_unit #(
  parameter logic [31:0] RESET_PC = 32'h0000_0000
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        stall,
  input  logic        redirect_valid,
  input  logic [31:0] redirect_pc,
  output logic        imem_req,
  output logic [31:0] imem_addr,
  input  logic        imem_ack,
  input  logic [31:0] imem_rdata,
  output logic        fd_load_enable,
  output logic [31:0] pc_value_next,
  output logic [31:0] next_instruction
);

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    REQ     = 2'd1,
    DISCARD = 2'd2
  } state_t;

  state_t      state;
  logic [31:0] fetch_pc;
  logic [31:0] req_addr;
  logic [31:0] req_next;
  logic [31:0] redir_aligned;
  logic [31:0] pc0, pc1, ins0, ins1;
  logic [1:0]  count;
  logic        pop;
  logic        push;
  logic        launch_ok;
  logic [2:0]  occ_after;

  assign redir_aligned = redirect_pc & 32'hFFFF_FFFC;
  assign req_next      = req_addr + 32'd4;

  assign pop       = (count != 2'd0) && !stall && !redirect_valid;
  assign push      = (state == REQ) && imem_ack && !redirect_valid;
  // Occupancy after this edge; a new request may only launch if it leaves room for its data.
  assign occ_after = {1'b0, count} + {2'b00, push} - {2'b00, pop};
  assign launch_ok = (occ_after <= 3'd1);

  assign imem_req         = (state != IDLE);
  assign imem_addr        = req_addr;
  assign fd_load_enable   = pop;
  assign pc_value_next    = pc0;
  assign next_instruction = ins0;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state    <= IDLE;
      fetch_pc <= RESET_PC;
      req_addr <= RESET_PC;
      count    <= '0;
      pc0      <= '0;
      pc1      <= '0;
      ins0     <= '0;
      ins1     <= '0;
    end else begin
      if (redirect_valid) begin
        count <= '0;
      end else begin
        case ({push, pop})
          2'b01: begin
            pc0   <= pc1;
            ins0  <= ins1;
            count <= count - 2'd1;
          end
          2'b10: begin
            if (count == 2'd0) begin
              pc0  <= req_next;
              ins0 <= imem_rdata;
            end else begin
              pc1  <= req_next;
              ins1 <= imem_rdata;
            end
            count <= count + 2'd1;
          end
          2'b11: begin
            if (count == 2'd1) begin
              pc0  <= req_next;
              ins0 <= imem_rdata;
            end else begin
              pc0  <= pc1;
              ins0 <= ins1;
              pc1  <= req_next;
              ins1 <= imem_rdata;
            end
          end
          default: ;
        endcase
      end

      case (state)
        IDLE: begin
          if (redirect_valid) begin
            state    <= REQ;
            req_addr <= redir_aligned;
            fetch_pc <= redir_aligned;
          end else if (launch_ok) begin
            state    <= REQ;
            req_addr <= fetch_pc;
          end
        end
        REQ: begin
          if (redirect_valid) begin
            fetch_pc <= redir_aligned;
            if (imem_ack) begin
              req_addr <= redir_aligned;
            end else begin
              state <= DISCARD;
            end
          end else if (imem_ack) begin
            fetch_pc <= req_next;
            if (launch_ok) begin
              req_addr <= req_next;
            end else begin
              state <= IDLE;
            end
          end
        end
        DISCARD: begin
          if (redirect_valid) begin
            fetch_pc <= redir_aligned;
          end
          if (imem_ack) begin
            state    <= REQ;
            req_addr <= redirect_valid ? redir_aligned : fetch_pc;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule
